// File: rtl/stopwatch_pkg.sv
// Shared definitions for the 60-second BCD stopwatch: state encoding,
// BCD digit limit and the terminal digit pattern.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Last count before the terminal value (59.99 s).
   localparam logic [3:0] TERM_D3 = 4'd5;
   localparam logic [3:0] TERM_D2 = 4'd9;
   localparam logic [3:0] TERM_D1 = 4'd9;
   localparam logic [3:0] TERM_D0 = 4'd9;

   // Terminal value (60.00 s).
   localparam logic [3:0] FINAL_D3 = 4'd6;
   localparam logic [3:0] FINAL_D2 = 4'd0;
   localparam logic [3:0] FINAL_D1 = 4'd0;
   localparam logic [3:0] FINAL_D0 = 4'd0;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch cascade. Wraps to 0 after MAX and offers a
// combinational carry so the whole chain ripples within a single clock.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       carry
);

   // Carry out only when this digit is about to wrap.
   assign carry = inc & (q == MAX);

   // Digit register: clear wins over increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 4'd0;
      end else if (clr) begin
         q <= 4'd0;
      end else if (inc) begin
         q <= (q == MAX) ? 4'd0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/stopwatch_60s_bcd.sv
// 60-second stopwatch core: run/pause FSM, 10 ms prescaler, terminal detect
// and four cascaded BCD digits feeding the seven-segment mux directly.
//
// state | meaning
// IDLE  | cleared at 00.00, waiting for start
// RUN   | prescaler counting, digits advance every TICK_DIV cycles
// PAUSE | prescaler and digits frozen, resumes with no phase loss
// DONE  | 60.00 reached, only clear or reset leaves
module stopwatch_60s_bcd
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 1_000_000,
   parameter int CNT_W    = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       clear,
   output logic [3:0] disp3,
   output logic [3:0] disp2,
   output logic [3:0] disp1,
   output logic [3:0] disp0,
   output logic       running,
   output logic       done,
   output logic       tick
);

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] prescaler;
   logic [CNT_W-1:0] prescaler_nxt;
   logic             incr;
   logic             at_terminal;
   logic             carry0;
   logic             carry1;
   logic             carry2;
   logic             carry3_unused;

   assign at_terminal = (disp3 == TERM_D3) && (disp2 == TERM_D2) &&
                        (disp1 == TERM_D1) && (disp0 == TERM_D0);

   // Next-state, prescaler and increment decode; clear overrides everything.
   always_comb begin
      state_nxt     = state;
      prescaler_nxt = prescaler;
      incr          = 1'b0;
      if (clear) begin
         state_nxt     = IDLE;
         prescaler_nxt = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_stop) begin
                  state_nxt     = RUN;
                  prescaler_nxt = '0;
               end
            end
            RUN: begin
               // Pausing suppresses the wrap so a pending tick is kept, not lost.
               if (start_stop) begin
                  state_nxt = PAUSE;
               end else if (prescaler == PRESC_LAST) begin
                  prescaler_nxt = '0;
                  incr          = 1'b1;
                  if (at_terminal) begin
                     state_nxt = DONE;
                  end
               end else begin
                  prescaler_nxt = prescaler + CNT_W'(1);
               end
            end
            PAUSE: begin
               if (start_stop) begin
                  state_nxt = RUN;
               end
            end
            DONE: begin
               prescaler_nxt = '0;
            end
            default: begin
               state_nxt     = IDLE;
               prescaler_nxt = '0;
            end
         endcase
      end
   end

   // State, prescaler and status flags, all registered together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         prescaler <= '0;
         tick      <= 1'b0;
         running   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         prescaler <= prescaler_nxt;
         tick      <= incr;
         running   <= (state_nxt == RUN);
         done      <= (state_nxt == DONE);
      end
   end

   bcd_digit_counter #(.MAX(BCD_MAX)) u_d0 (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (incr),
      .q     (disp0),
      .carry (carry0)
   );

   bcd_digit_counter #(.MAX(BCD_MAX)) u_d1 (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (carry0),
      .q     (disp1),
      .carry (carry1)
   );

   bcd_digit_counter #(.MAX(BCD_MAX)) u_d2 (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (carry1),
      .q     (disp2),
      .carry (carry2)
   );

   // Tens of seconds stops at 6; the count never gets past 60.00.
   bcd_digit_counter #(.MAX(FINAL_D3)) u_d3 (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .inc   (carry2),
      .q     (disp3),
      .carry (carry3_unused)
   );

endmodule

// File: tb/tb_stopwatch_60s_bcd.sv
// Bench for the 60-second stopwatch with TICK_DIV=4. A reference model tracks
// elapsed hundredths as a plain integer and derives digits arithmetically.
module tb_stopwatch_60s_bcd;

   localparam int TICK_DIV = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] disp3, disp2, disp1, disp0;
   logic       running, done, tick;

   int n_assert = 0;
   int n_fail   = 0;

   int m_mode   = M_IDLE;
   int m_phase  = 0;
   int m_ticks  = 0;
   bit m_tick   = 1'b0;

   stopwatch_60s_bcd #(.TICK_DIV(TICK_DIV), .CNT_W(20)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .clear      (clear),
      .disp3      (disp3),
      .disp2      (disp2),
      .disp1      (disp1),
      .disp0      (disp0),
      .running    (running),
      .done       (done),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_mode  = M_IDLE;
      m_phase = 0;
      m_ticks = 0;
      m_tick  = 1'b0;
   endfunction

   // One clock edge of the stopwatch rules, in elapsed-hundredths terms.
   function automatic void model_step(input bit ss, input bit cl);
      m_tick = 1'b0;
      if (cl) begin
         model_reset();
      end else begin
         case (m_mode)
            M_IDLE:  if (ss) begin m_mode = M_RUN; m_phase = 0; end
            M_RUN: begin
               if (ss) m_mode = M_PAUSE;
               else begin
                  m_phase++;
                  if (m_phase == TICK_DIV) begin
                     m_phase = 0;
                     m_ticks++;
                     m_tick = 1'b1;
                     if (m_ticks == 6000) m_mode = M_DONE;
                  end
               end
            end
            M_PAUSE: if (ss) m_mode = M_RUN;
            default: ;
         endcase
      end
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".disp3"}, 32'(disp3), 32'(m_ticks / 1000));
      chk({tag, ".disp2"}, 32'(disp2), 32'((m_ticks / 100) % 10));
      chk({tag, ".disp1"}, 32'(disp1), 32'((m_ticks / 10) % 10));
      chk({tag, ".disp0"}, 32'(disp0), 32'(m_ticks % 10));
      chk({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
      chk({tag, ".done"}, 32'(done), 32'(m_mode == M_DONE));
      chk({tag, ".tick"}, 32'(tick), 32'(m_tick));
   endtask

   task automatic step(input bit ss, input bit cl, input string tag);
      start_stop = ss;
      clear      = cl;
      @(posedge clk);
      model_step(ss, cl);
      #1;
      start_stop = 1'b0;
      clear      = 1'b0;
      check_all(tag);
   endtask

   task automatic run_to_ticks(input int target, input int budget, input string tag);
      int n = 0;
      while (m_ticks != target && n < budget) begin
         step(1'b0, 1'b0, tag);
         n++;
      end
      chk({tag, ".reach"}, 32'(m_ticks), 32'(target));
   endtask

   initial begin
      int gap;
      int last_tick;
      int ticks_seen;

      // Reset and idle.
      #1;
      check_all("reset");
      #12;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "idle");

      // Run 40 cycles: ten ticks exactly four cycles apart.
      step(1'b1, 1'b0, "start");
      last_tick  = 0;
      ticks_seen = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1'b0, 1'b0, "run40");
         if (tick) begin
            gap = i - last_tick;
            chk("tick_gap", 32'(gap), 32'(TICK_DIV));
            last_tick = i;
            ticks_seen++;
         end
      end
      chk("ticks_in_40", 32'(ticks_seen), 32'd10);
      chk("run40.disp1", 32'(disp1), 32'd1);
      chk("run40.disp0", 32'(disp0), 32'd0);

      // Pause with two prescaler cycles elapsed, hold, resume.
      step(1'b0, 1'b0, "pre_pause");
      step(1'b0, 1'b0, "pre_pause");
      chk("phase_before_pause", 32'(m_phase), 32'd2);
      step(1'b1, 1'b0, "pause");
      for (int i = 0; i < 10 + $urandom_range(0, 5); i++) step(1'b0, 1'b0, "paused");
      chk("frozen.disp1", 32'(disp1), 32'd1);
      step(1'b1, 1'b0, "resume");
      step(1'b0, 1'b0, "resume1");
      chk("resume1.tick", 32'(tick), 32'd0);
      step(1'b0, 1'b0, "resume2");
      chk("resume2.tick", 32'(tick), 32'd1);
      chk("resume2.disp0", 32'(disp0), 32'd1);

      // Randomized run/pause/clear activity.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0), "random");
      end

      // Carry chain from 00.00 to 10.00.
      step(1'b0, 1'b1, "clear_before_carry");
      step(1'b1, 1'b0, "start_carry");
      run_to_ticks(99, 1000, "to_0099");
      chk("0099.disp1", 32'(disp1), 32'd9);
      run_to_ticks(100, 10, "to_0100");
      chk("0100.disp2", 32'(disp2), 32'd1);
      chk("0100.disp0", 32'(disp0), 32'd0);
      run_to_ticks(999, 4000, "to_0999");
      chk("0999.disp2", 32'(disp2), 32'd9);
      run_to_ticks(1000, 10, "to_1000");
      chk("1000.disp3", 32'(disp3), 32'd1);
      chk("1000.disp2", 32'(disp2), 32'd0);

      // Terminal at 60.00.
      run_to_ticks(6000, 22000, "to_6000");
      chk("6000.disp3", 32'(disp3), 32'd6);
      chk("6000.done", 32'(done), 32'd1);
      chk("6000.running", 32'(running), 32'd0);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, "done_hold");
      step(1'b1, 1'b0, "done_ss");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "done_hold2");
      chk("done_ss.disp3", 32'(disp3), 32'd6);
      step(1'b0, 1'b1, "done_clear");
      chk("done_clear.done", 32'(done), 32'd0);
      chk("done_clear.disp3", 32'(disp3), 32'd0);

      // Clear beats start_stop while running.
      step(1'b1, 1'b0, "start_prio");
      run_to_ticks(7, 100, "to_0007");
      step(1'b1, 1'b1, "clear_and_ss");
      chk("prio.running", 32'(running), 32'd0);
      chk("prio.disp0", 32'(disp0), 32'd0);

      // Asynchronous reset in the middle of a cycle at 34.56.
      step(1'b1, 1'b0, "start_rst");
      run_to_ticks(3456, 15000, "to_3456");
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_60s_bcd.md
Name: stopwatch_60s_bcd

Overview:
Stopwatch core for the 60-second timer. It counts elapsed time from 00.00 to 60.00 seconds in 10 ms steps and presents four BCD digits. These feed the four-digit seven-segment multiplexing driver directly: disp3 = seconds tens, disp2 = seconds units, disp1 = tenths, disp0 = hundredths. Start/stop and clear come from already-debounced, single-cycle button pulses.

Parameters:
TICK_DIV, 1_000_000, clk cycles per 10 ms tick (100 MHz board clock); the bench sets 4.
CNT_W, 20, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_stop  in  1  single-cycle pulse; toggles run/pause
clear  in  1  single-cycle pulse; returns to 00.00 idle
disp3  out  4  seconds tens, BCD 0-6
disp2  out  4  seconds units, BCD 0-9
disp1  out  4  tenths, BCD 0-9
disp0  out  4  hundredths, BCD 0-9
running  out  1  high while in RUN
done  out  1  high while in DONE (60.00 reached)
tick  out  1  one-cycle pulse on each 10 ms increment

Behaviour:
- Reset (async, rst=1): state=IDLE, prescaler=0, all disp=0, running=0, done=0, tick=0. All outputs are registered.
- States: IDLE, RUN, PAUSE, DONE. Encoding is 2-bit: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Transitions, evaluated on each rising clk edge:
  - clear=1 in any state -> IDLE, digits=0000, prescaler=0. Clear beats start_stop in the same cycle.
  - IDLE + start_stop -> RUN. Prescaler starts from 0.
  - RUN + start_stop -> PAUSE. Prescaler and digits hold; no tick occurs on that edge, even if the prescaler was at TICK_DIV-1.
  - PAUSE + start_stop -> RUN. Resumes from the held prescaler value, with no phase loss.
  - DONE: start_stop is ignored; only clear or rst exits.
- Prescaler: counts only in RUN. At TICK_DIV-1 it wraps to 0 and raises an internal increment.
  - The tick output is registered and asserted in the same cycle the new digit value appears.
  - Digit update latency from the increment condition is 1 clk.
- Digit arithmetic (BCD cascade, ripple carry within one cycle):
  - disp0 goes 0..9; at 9 it wraps to 0 and carries.
  - disp1 goes 0..9; it carries at 9.
  - disp2 goes 0..9; it carries at 9.
  - disp3 increments on carry.
  - Digits never take a non-BCD value.
- Terminal: an increment from 5,9,9,9 produces 6,0,0,0 and moves to DONE on the same edge.
  - done=1 and running=0 from that edge.
  - The prescaler is forced to 0.
  - No further increments occur.
- running = (state==RUN); done = (state==DONE). Both are registered with the state.
- Reset mid-operation: immediate asynchronous return to the reset values above.
- Pulses wider than one cycle count as repeated toggles. Upstream guarantees single-cycle pulses; this block does no edge detection.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encodings IDLE/RUN/PAUSE/DONE
  - BCD_MAX=4'd9
  - terminal digit constants 5,9,9,9 and final 6,0,0,0
- Sub-module bcd_digit_counter, instantiated four times:
  - inputs: clk, rst, clr, inc
  - outputs: q[3:0], carry (combinational, = inc & q==MAX)
  - parameter MAX
- The top level holds the FSM, prescaler, terminal detect and tick register.

Test Plan (TICK_DIV=4):
- Reset then idle 20 cycles -> disp=0000, running=0, done=0, tick never asserted.
- start_stop pulse, run 40 cycles -> 10 tick pulses spaced exactly 4 cycles apart; disp=0,0,1,0; running=1.
- Pause/resume phase: start_stop at prescaler=2, hold 10 cycles, start_stop again -> digits frozen during PAUSE; next tick exactly 2 cycles after resume.
- Carry chain: run from 0 for 1000 ticks -> disp=1,0,0,0, with intermediate checks at 0,0,9,9 -> 0,1,0,0 and 0,9,9,9 -> 1,0,0,0.
- Terminal: run 6000 ticks -> disp=6,0,0,0, done=1, running=0, no tick afterward. A further start_stop does nothing; clear gives 0000 in IDLE with done=0.
- Priority/async: clear and start_stop in the same cycle while in RUN -> IDLE, 0000. Assert rst mid-count at 3,4,5,6 -> outputs 0 before the next clk edge.
